// File: rtl/neuraedge_npu_50tops_top.sv
// neuraedge_npu_50tops_top
// Control and status shell of the NeuraEdge 50-TOPS NPU prototype.
//
// Purpose:
//   - Zero-wait CSR bus. Register writes commit on the clock edge and reads are
//     a combinational decode of the address.
//   - 512-bit ingress beat port. Accepted beats are counted and their bytes summed.
//   - Power and thermal throttle status.
//   - Token-bucket admission for the shared-DRAM contention wrapper, controlled
//     through CONT (0xD4).
//
// Ports:
//   clk                      sole clock, rising edge
//   reset                    synchronous, active-low
//   power_mode[7:0]          mirrored in STATUS[15:8]
//   system_power_budget_mw   throttle input (budget floor BUDGET_MIN_MW)
//   chip_temperature[7:0]    throttle input (limit TEMP_LIMIT)
//   performance_target_tops  mirrored in PERF[15:0]
//   global_sparsity_enable   mirrored in STATUS[16]
//   global_sparsity_mode     mirrored in STATUS[18:17]
//   global_precision_mode    mirrored in STATUS[20:19]
//   data_in[511:0]           ingress beat, byte k = data_in[8k+7:8k]
//   data_valid               ingress beat offered this cycle
//   csr_valid/csr_write      CSR request, 1 = write
//   csr_addr[7:0]            byte address, word aligned
//   csr_wdata[31:0]          write data
//   csr_rdata[31:0]          read data (0 when not a read)
//   csr_ready                equals csr_valid
module neuraedge_npu_50tops_top #(
   parameter logic [31:0] ID_VALUE      = 32'h4E45_5032,
   parameter logic [7:0]  TEMP_LIMIT    = 8'd95,
   parameter logic [15:0] BUDGET_MIN_MW = 16'd500
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [7:0]   power_mode,
   input  logic [15:0]  system_power_budget_mw,
   input  logic [7:0]   chip_temperature,
   input  logic [15:0]  performance_target_tops,
   input  logic         global_sparsity_enable,
   input  logic [1:0]   global_sparsity_mode,
   input  logic [1:0]   global_precision_mode,
   input  logic [511:0] data_in,
   input  logic         data_valid,
   input  logic         csr_valid,
   input  logic         csr_write,
   input  logic [7:0]   csr_addr,
   input  logic [31:0]  csr_wdata,
   output logic [31:0]  csr_rdata,
   output logic         csr_ready
);

   localparam int DATA_W = 512;
   localparam int NBYTES = DATA_W / 8;

   localparam logic [7:0] A_ID     = 8'h00;
   localparam logic [7:0] A_CTRL   = 8'h04;
   localparam logic [7:0] A_STATUS = 8'h08;
   localparam logic [7:0] A_PERF   = 8'h0C;
   localparam logic [7:0] A_BEATS  = 8'h10;
   localparam logic [7:0] A_SUM    = 8'h14;
   localparam logic [7:0] A_CONT   = 8'hD4;
   localparam logic [7:0] A_STALLS = 8'hD8;
   localparam logic [7:0] A_TOKENS = 8'hDC;

   // Sum of all bytes of one beat; 64 * 255 fits in 14 bits.
   function automatic logic [13:0] byte_sum(input logic [DATA_W-1:0] beat);
      logic [13:0] acc;
      acc = '0;
      for (int k = 0; k < NBYTES; k++) begin
         acc = acc + {6'd0, beat[8*k +: 8]};
      end
      return acc;
   endfunction

   // Registered state
   logic        ctrl_en;
   logic        cont_en;
   logic [7:0]  tok_max;
   logic [7:0]  refill_per;
   logic [31:0] beats;
   logic [31:0] sum;
   logic [31:0] stalls;
   logic [7:0]  tokens;
   logic [7:0]  refill_cnt;

   // Combinational control
   logic        csr_wr;
   logic        csr_rd;
   logic        throttle;
   logic [7:0]  refill_eff;
   logic        offered;
   logic        accept;
   logic        stall;
   logic        clear;
   logic        cont_wr;
   logic        cont_rise;
   logic        refill_evt;
   logic        consume;
   logic [7:0]  tok_next;

   assign csr_ready = csr_valid;
   assign csr_wr    = csr_valid & csr_write;
   assign csr_rd    = csr_valid & ~csr_write;

   assign throttle  = (chip_temperature >= TEMP_LIMIT) |
                      (system_power_budget_mw < BUDGET_MIN_MW);

   // A refill period of 0 behaves as 1 (refill every cycle).
   assign refill_eff = (refill_per == 8'd0) ? 8'd1 : refill_per;

   assign offered = data_valid & ctrl_en;
   assign accept  = offered & ~throttle & (~cont_en | (tokens != 8'd0));
   assign stall   = offered & ~accept;
   assign consume = accept & cont_en;

   assign clear     = csr_wr & (csr_addr == A_CTRL) & csr_wdata[1];
   assign cont_wr   = csr_wr & (csr_addr == A_CONT);
   assign cont_rise = cont_wr & csr_wdata[0] & ~cont_en;

   // ">=" lets the counter recover when the period is shortened below its value.
   assign refill_evt = cont_en & (refill_cnt >= (refill_eff - 8'd1));

   // Token update. Refill and consume in the same cycle cancel. The result is
   // clamped to the bucket depth, which also covers a shrunk TOK_MAX.
   always_comb begin
      tok_next = tokens;
      if (refill_evt && !consume) begin
         tok_next = (tokens >= tok_max) ? tok_max : tokens + 8'd1;
      end else if (consume && !refill_evt) begin
         tok_next = tokens - 8'd1;
      end
      if (tok_next > tok_max) begin
         tok_next = tok_max;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         ctrl_en    <= 1'b1;
         cont_en    <= 1'b0;
         tok_max    <= 8'd4;
         refill_per <= 8'd1;
         beats      <= '0;
         sum        <= '0;
         stalls     <= '0;
         tokens     <= 8'd4;
         refill_cnt <= '0;
      end else begin
         if (csr_wr && csr_addr == A_CTRL) begin
            ctrl_en <= csr_wdata[0];
         end
         if (cont_wr) begin
            cont_en    <= csr_wdata[0];
            tok_max    <= csr_wdata[15:8];
            refill_per <= csr_wdata[23:16];
         end

         // Enabling contention starts from a full bucket and a fresh period.
         if (cont_rise) begin
            tokens     <= csr_wdata[15:8];
            refill_cnt <= '0;
         end else begin
            tokens <= tok_next;
            if (cont_en) begin
               refill_cnt <= refill_evt ? 8'd0 : refill_cnt + 8'd1;
            end
         end

         // A clear takes priority over a same-cycle accept or stall.
         if (clear) begin
            beats  <= '0;
            sum    <= '0;
            stalls <= '0;
         end else begin
            if (accept) begin
               beats <= beats + 32'd1;
               sum   <= sum + {18'd0, byte_sum(data_in)};
            end
            if (stall) begin
               stalls <= stalls + 32'd1;
            end
         end
      end
   end

   always_comb begin
      csr_rdata = '0;
      if (csr_rd) begin
         case (csr_addr)
            A_ID:     csr_rdata = ID_VALUE;
            A_CTRL:   csr_rdata = {31'd0, ctrl_en};
            A_STATUS: csr_rdata = {11'd0, global_precision_mode, global_sparsity_mode,
                                   global_sparsity_enable, power_mode, 7'd0, throttle};
            A_PERF:   csr_rdata = {16'd0, performance_target_tops};
            A_BEATS:  csr_rdata = beats;
            A_SUM:    csr_rdata = sum;
            A_CONT:   csr_rdata = {8'd0, refill_per, tok_max, 7'd0, cont_en};
            A_STALLS: csr_rdata = stalls;
            A_TOKENS: csr_rdata = {24'd0, tokens};
            default:  csr_rdata = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_neuraedge_npu_50tops_top.sv
// Testbench for neuraedge_npu_50tops_top: directed CSR and ingress stimulus.
// Reads push the expected value into a queue; a monitor pops and compares on
// the falling edge whenever a CSR read is presented.
module tb_neuraedge_npu_50tops_top;

   logic         clk = 1'b0;
   logic         reset;
   logic [7:0]   power_mode;
   logic [15:0]  system_power_budget_mw;
   logic [7:0]   chip_temperature;
   logic [15:0]  performance_target_tops;
   logic         global_sparsity_enable;
   logic [1:0]   global_sparsity_mode;
   logic [1:0]   global_precision_mode;
   logic [511:0] data_in;
   logic         data_valid;
   logic         csr_valid;
   logic         csr_write;
   logic [7:0]   csr_addr;
   logic [31:0]  csr_wdata;
   logic [31:0]  csr_rdata;
   logic         csr_ready;

   int checks = 0;
   int fails  = 0;

   logic [7:0]  exp_addr_q[$];
   logic [31:0] exp_data_q[$];

   localparam logic [31:0] ID_EXP     = 32'h4E45_5032;
   localparam logic [31:0] STATUS_EXP = 32'h000D_5A00;

   neuraedge_npu_50tops_top dut (
      .clk                     (clk),
      .reset                   (reset),
      .power_mode              (power_mode),
      .system_power_budget_mw  (system_power_budget_mw),
      .chip_temperature        (chip_temperature),
      .performance_target_tops (performance_target_tops),
      .global_sparsity_enable  (global_sparsity_enable),
      .global_sparsity_mode    (global_sparsity_mode),
      .global_precision_mode   (global_precision_mode),
      .data_in                 (data_in),
      .data_valid              (data_valid),
      .csr_valid               (csr_valid),
      .csr_write               (csr_write),
      .csr_addr                (csr_addr),
      .csr_wdata               (csr_wdata),
      .csr_rdata               (csr_rdata),
      .csr_ready               (csr_ready)
   );

   always #5 clk = ~clk;

   // Monitor: compares read data and the zero-wait ready
   always @(negedge clk) begin
      if (csr_valid) begin
         checks++;
         if (csr_ready !== 1'b1) begin
            fails++;
            $display("FAIL csr_ready addr=0x%02h got=%b exp=1", csr_addr, csr_ready);
         end
      end
      if (csr_valid && !csr_write) begin
         checks++;
         if (exp_data_q.size() == 0) begin
            fails++;
            $display("FAIL rd_unexpected addr=0x%02h got=0x%08h exp=none", csr_addr, csr_rdata);
         end else begin
            logic [7:0]  ea;
            logic [31:0] ed;
            ea = exp_addr_q.pop_front();
            ed = exp_data_q.pop_front();
            if (csr_addr !== ea || csr_rdata !== ed) begin
               fails++;
               $display("FAIL rd_0x%02h got=0x%08h exp=0x%08h (addr seen 0x%02h)",
                        ea, csr_rdata, ed, csr_addr);
            end
         end
      end
   end

   task automatic csr_wr(input logic [7:0] a, input logic [31:0] d);
      csr_valid = 1'b1; csr_write = 1'b1; csr_addr = a; csr_wdata = d;
      @(posedge clk); #1;
      csr_valid = 1'b0; csr_write = 1'b0;
   endtask

   task automatic csr_rd(input logic [7:0] a, input logic [31:0] e);
      exp_addr_q.push_back(a);
      exp_data_q.push_back(e);
      csr_valid = 1'b1; csr_write = 1'b0; csr_addr = a;
      @(posedge clk); #1;
      csr_valid = 1'b0;
   endtask

   task automatic drive_beats(input int n, input logic [511:0] pat);
      data_valid = 1'b1; data_in = pat;
      repeat (n) begin
         @(posedge clk); #1;
      end
      data_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [511:0] ones, ramp, allff;
      for (int k = 0; k < 64; k++) begin
         ones[8*k +: 8] = 8'h01;
         ramp[8*k +: 8] = 8'(k);
         allff[8*k +: 8] = 8'hFF;
      end

      reset = 1'b0;
      power_mode = 8'h5A; system_power_budget_mw = 16'd1000; chip_temperature = 8'd40;
      performance_target_tops = 16'd50; global_sparsity_enable = 1'b1;
      global_sparsity_mode = 2'd2; global_precision_mode = 2'd1;
      data_in = '0; data_valid = 1'b0;
      csr_valid = 1'b0; csr_write = 1'b0; csr_addr = '0; csr_wdata = '0;
      idle(10);
      reset = 1'b1;

      // Reset state and read-only decode
      csr_rd(8'h00, ID_EXP);
      csr_rd(8'hD4, 32'h0001_0400);
      csr_rd(8'h04, 32'h1);
      csr_rd(8'h10, 32'h0);
      csr_rd(8'h14, 32'h0);
      csr_rd(8'hD8, 32'h0);
      csr_rd(8'hDC, 32'h4);
      csr_rd(8'h08, STATUS_EXP);
      csr_rd(8'h0C, 32'd50);
      csr_rd(8'h20, 32'h0);
      csr_wr(8'h00, 32'h1234_5678);
      csr_rd(8'h00, ID_EXP);

      // Zero-depth bucket stalls everything; disabling lets beats through
      csr_wr(8'hD4, 32'h1);
      csr_rd(8'hD4, 32'h1);
      csr_rd(8'hDC, 32'h0);
      drive_beats(5, '0);
      csr_rd(8'hD8, 32'd5);
      csr_rd(8'h10, 32'd0);
      csr_wr(8'hD4, 32'h0);
      drive_beats(100, '0);
      csr_rd(8'hD8, 32'd5);
      csr_rd(8'h10, 32'd100);

      // Depth 4, refill every 4 cycles, 20 back-to-back beats
      csr_wr(8'h04, 32'h3);
      csr_rd(8'h10, 32'd0);
      csr_wr(8'hD4, 32'h0004_0401);
      drive_beats(20, '0);
      csr_rd(8'hDC, 32'd1);
      csr_rd(8'h10, 32'd8);
      csr_rd(8'hD8, 32'd12);
      csr_wr(8'hD4, 32'h0);

      // Byte sums and counter clear
      csr_wr(8'h04, 32'h3);
      drive_beats(3, ones);
      csr_rd(8'h14, 32'd192);
      csr_rd(8'h10, 32'd3);
      drive_beats(1, ramp);
      csr_rd(8'h14, 32'd2208);
      drive_beats(1, allff);
      csr_rd(8'h14, 32'd18528);
      csr_rd(8'h10, 32'd5);
      csr_wr(8'h04, 32'h3);
      csr_rd(8'h10, 32'd0);
      csr_rd(8'h14, 32'd0);
      csr_rd(8'hD8, 32'd0);
      csr_rd(8'h04, 32'h1);

      // Ingress disabled: neither counted nor stalled
      csr_wr(8'h04, 32'h0);
      drive_beats(4, ones);
      csr_rd(8'h10, 32'd0);
      csr_rd(8'hD8, 32'd0);
      csr_wr(8'h04, 32'h1);

      // Clear in the same cycle as an accepted beat wins
      data_valid = 1'b1; data_in = ones;
      csr_wr(8'h04, 32'h3);
      data_valid = 1'b0;
      csr_rd(8'h10, 32'd0);
      csr_rd(8'h14, 32'd0);

      // Thermal and power throttle
      chip_temperature = 8'd95;
      drive_beats(5, ones);
      csr_rd(8'h08, STATUS_EXP | 32'h1);
      csr_rd(8'hD8, 32'd5);
      csr_rd(8'h10, 32'd0);
      chip_temperature = 8'd94;
      drive_beats(2, ones);
      csr_rd(8'h10, 32'd2);
      csr_rd(8'h08, STATUS_EXP);
      system_power_budget_mw = 16'd499;
      drive_beats(1, ones);
      csr_rd(8'hD8, 32'd6);
      system_power_budget_mw = 16'd500;
      drive_beats(1, ones);
      csr_rd(8'h10, 32'd3);
      system_power_budget_mw = 16'd1000;

      // Shrinking TOK_MAX clamps the token count
      csr_wr(8'hD4, 32'h0001_0801);
      csr_rd(8'hDC, 32'd8);
      csr_wr(8'hD4, 32'h0001_0201);
      idle(1);
      csr_rd(8'hDC, 32'd2);
      csr_wr(8'hD4, 32'h0);
      csr_rd(8'hD4, 32'h0);

      // Reset during a CONT write discards the write
      reset = 1'b0;
      csr_wr(8'hD4, 32'h00FF_FF01);
      idle(2);
      reset = 1'b1;
      csr_rd(8'hD4, 32'h0001_0400);
      csr_rd(8'hDC, 32'd4);
      csr_rd(8'h04, 32'h1);
      csr_rd(8'h10, 32'd0);

      idle(3);
      checks++;
      if (exp_data_q.size() != 0) begin
         fails++;
         $display("FAIL leftover_reads got=%0d exp=0", exp_data_q.size());
      end
      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule

// File: doc/neuraedge_npu_50tops_top.md
# neuraedge_npu_50tops_top

Top-level control and status shell of the NeuraEdge 50-TOPS NPU prototype. It exposes a zero-wait CSR bus and a 512-bit ingress beat port. It accumulates ingress statistics and reports power and thermal throttle status. It also hosts the control registers and token-bucket admission logic of the shared-DRAM memory contention wrapper, which system benches toggle through CSR 0xD4.

## Interface
Parameters:
- `ID_VALUE`, 32'h4E45_5032: value returned at CSR 0x00.
- `TEMP_LIMIT`, 8'd95: throttle temperature threshold in °C.
- `BUDGET_MIN_MW`, 16'd500: throttle power-budget floor.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `power_mode`  in  8  mirrored in STATUS[15:8].
- `system_power_budget_mw`  in  16  power budget, used for throttle.
- `chip_temperature`  in  8  die temperature in °C, used for throttle.
- `performance_target_tops`  in  16  mirrored in CSR 0x0C[15:0].
- `global_sparsity_enable`  in  1  mirrored in STATUS[16].
- `global_sparsity_mode`  in  2  mirrored in STATUS[18:17].
- `global_precision_mode`  in  2  mirrored in STATUS[20:19].
- `data_in`  in  512  64 bytes; byte k is `data_in[8k+7:8k]`.
- `data_valid`  in  1  ingress beat offered this cycle.
- `csr_valid`  in  1  CSR request.
- `csr_write`  in  1  1 = write, 0 = read.
- `csr_addr`  in  8  byte address, word-aligned.
- `csr_wdata`  in  32  write data.
- `csr_rdata`  out  32  read data.
- `csr_ready`  out  1  request complete.

## Operation
- **CSR handshake.** `csr_ready` equals `csr_valid` (combinational, zero wait).
  - Writes commit at every rising edge where `csr_valid & csr_write` is high, so a repeated commit has no further effect.
  - `csr_rdata` is a combinational decode of `csr_addr` when `csr_valid & ~csr_write`, and 0 otherwise.
  - Reads have no side effects.
  - Unmapped addresses read 0; writes to them are ignored.
  - Writes to read-only registers are ignored.
- **CSR map.**
  - 0x00 ID (RO): `ID_VALUE`.
  - 0x04 CTRL (RW): bit0 = ingress enable; bit1 = counter clear, self-clearing, write 1 to clear BEATS/SUM/STALLS. Reset value 0x1.
  - 0x08 STATUS (RO): bit0 = throttle; [15:8] = power_mode; [16] = sparsity enable; [18:17] = sparsity mode; [20:19] = precision mode.
  - 0x0C PERF (RO): [15:0] = performance_target_tops.
  - 0x10 BEATS (RO): accepted-beat count, 32-bit, wraps.
  - 0x14 SUM (RO): sum of all 64 bytes of every accepted beat, mod 2^32.
  - 0xD4 CONT (RW): bit0 = contention enable; [15:8] = bucket depth TOK_MAX; [23:16] = refill period REFILL (0 is treated as 1). Reset value 0x0001_0400 (disabled, depth 4, refill 1).
  - 0xD8 STALLS (RO): beats rejected by contention or throttle, 32-bit, wraps.
  - 0xDC TOKENS (RO): [7:0] = current token count.
- **Throttle.** `throttle = (chip_temperature >= TEMP_LIMIT) | (system_power_budget_mw < BUDGET_MIN_MW)`, evaluated combinationally.
- **Ingress admission.** A beat is offered when `data_valid & CTRL[0]`.
  - Accepted if `~throttle` and either contention is disabled or the token count is greater than 0.
  - Otherwise it is rejected and STALLS increments.
  - Beats with CTRL[0] = 0 are neither counted nor stalled.
- **Token bucket.**
  - A refill counter counts cycles while contention is enabled. When it reaches REFILL-1, it wraps to 0 and tokens increment, saturating at TOK_MAX.
  - An accepted beat under contention consumes one token.
  - A refill and a consume in the same cycle leave the token count unchanged.
  - A CONT write that sets bit0 from 0 to 1 reloads tokens to TOK_MAX and zeroes the refill counter.
  - If TOK_MAX is rewritten below the current count, the count clamps to TOK_MAX on the next edge.
  - With TOK_MAX = 0, every offered beat stalls.
- **Counter-clear priority.** A counter clear in the same cycle as an accepted beat wins: the counters become 0.

## Timing
- Reset (`reset` = 0 at an edge) values: CTRL = 0x1, CONT = 0x0001_0400, BEATS = SUM = STALLS = 0, tokens = 4, refill counter = 0.
- While `reset` is 0, `csr_ready` still follows `csr_valid`; CSR writes are ignored.
- Reset asserted mid-transaction discards the write.
- Counter, token, and CSR updates are visible on `csr_rdata` one cycle after the triggering edge.
- Ingress has no backpressure; a rejected beat is lost.
- Throttle changes take effect in the same cycle.

## Test plan
- Reset 10 cycles, then read 0x00 -> `ID_VALUE`; read 0xD4 -> 0x0001_0400; `csr_ready` high on the same cycle as `csr_valid`.
- Write 0xD4 = 0x1, read back -> 0x0000_0001 with tokens = 0 and all beats stalling; write 0xD4 = 0x0, drive 100 cycles of `data_valid` -> STALLS unchanged, BEATS += 100.
- Write CONT = 0x0004_0401 (depth 4, refill 4), drive `data_valid` continuously for 20 cycles -> BEATS = 8, STALLS = 12.
- Drive 3 beats with every byte = 0x01 -> SUM = 192, BEATS = 3; write CTRL = 0x3 -> BEATS, SUM, STALLS read 0 and CTRL reads 0x1.
- Set chip_temperature = 95 with 5 beats -> STATUS[0] = 1, STALLS = 5, BEATS unchanged; set chip_temperature = 94 -> beats accepted again.
- Assert `reset` low during a write to 0xD4 -> CONT retains its reset value.
